// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store sequencer in front of a word-wide data memory.
// Byte/half stores go through read-modify-write; loads are lane-selected and extended.
module lsu_mem_ctrl #(
   parameter int MEM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_wr_en,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [2:0] {IDLE, RD, LATCH, WR, RESP} state_t;

   state_t      state, state_nx;
   logic [1:0]  addr_q;
   logic [15:0] wdata_q;
   logic        we_q;
   logic [2:0]  f3_q;

   logic        acc, bad_f3, misal, oor, err;
   logic [31:0] base, ld_data, mrg;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign req_ready = (state == IDLE);
   assign acc       = req_valid & req_ready;
   assign base      = {req_addr[31:2], 2'b00};

   assign bad_f3 = (req_funct3 == 3'b011)
                 | (req_funct3[2] & req_funct3[1])
                 | (req_we & req_funct3[2]);
   assign misal  = ((req_funct3[1:0] == 2'b01) & req_addr[0])
                 | ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
   assign oor    = base > 32'(MEM_BYTES - 4);
   assign err    = bad_f3 | misal | oor;

   assign byte_sel = mem_rdata[{addr_q, 3'b000} +: 8];
   assign half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

   // funct3[2] set means zero-extend (BU/HU)
   always_comb begin
      ld_data = mem_rdata;
      unique case (f3_q[1:0])
         2'b00:   ld_data = {{24{byte_sel[7] & ~f3_q[2]}}, byte_sel};
         2'b01:   ld_data = {{16{half_sel[15] & ~f3_q[2]}}, half_sel};
         default: ld_data = mem_rdata;
      endcase
   end

   always_comb begin
      mrg = mem_rdata;
      if (f3_q[1:0] == 2'b00)
         mrg[{addr_q, 3'b000} +: 8] = wdata_q[7:0];
      else
         mrg[{addr_q[1], 4'b0000} +: 16] = wdata_q;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (acc) begin
               if (err)
                  state_nx = RESP;
               else if (req_we && req_funct3 == 3'b010)
                  state_nx = WR;
               else
                  state_nx = RD;
            end
         end
         RD:      state_nx = LATCH;
         LATCH:   state_nx = we_q ? WR : RESP;
         WR:      state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         f3_q      <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state <= state_nx;
         if (acc) begin
            addr_q    <= req_addr[1:0];
            wdata_q   <= req_wdata[15:0];
            we_q      <= req_we;
            f3_q      <= req_funct3;
            rsp_err   <= err;
            rsp_rdata <= '0;
            // rejected requests leave the memory port untouched
            if (!err) begin
               mem_addr  <= base;
               mem_wdata <= req_wdata;
            end
         end
         if (state == LATCH) begin
            if (we_q)
               mem_wdata <= mrg;
            else
               rsp_rdata <= ld_data;
         end
      end
   end

   assign rsp_valid = (state == RESP);
   assign mem_wr_en = (state == WR) & rst_n;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed table, hand-built corner sequences and random
// traffic against a byte-level reference model of the data memory.
module tb_lsu_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_wr_en;
   logic [31:0] mem_rdata = '0;

   logic [31:0] mem_arr [256] = '{default: 32'h0};
   logic [31:0] ref_mem [256];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   lsu_mem_ctrl #(.MEM_BYTES(1024)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wr_en  (mem_wr_en),
      .mem_rdata  (mem_rdata)
   );

   always @(posedge clk) mem_rdata <= mem_arr[mem_addr[9:2]];
   always @(negedge clk) if (mem_wr_en) mem_arr[mem_addr[9:2]] <= mem_wdata;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        e_err;
      logic [31:0] e_rd;
      int          e_lat;
      int          e_wr;
   } vec_t;

   vec_t vec [23];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: memory as bytes, accesses by size/offset rules
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic err, output logic [31:0] rd,
                        output int lat, output int nwr);
      int size, off;
      logic [31:0] w;
      bit ill, mis, oor;
      ill  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3 > 3'd2);
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      mis  = (addr & 32'(size - 1)) != 0;
      oor  = (addr & 32'hFFFF_FFFC) > 32'd1020;
      err  = ill || mis || oor;
      rd   = '0;
      nwr  = 0;
      off  = int'(addr[1:0]);
      if (err) begin
         lat = 1;
      end else if (!we) begin
         w  = ref_mem[addr[9:2]];
         rd = w >> (8 * off);
         if (size == 1) rd = (!f3[2] && rd[7])  ? (rd | 32'hFFFF_FF00) : (rd & 32'hFF);
         if (size == 2) rd = (!f3[2] && rd[15]) ? (rd | 32'hFFFF_0000) : (rd & 32'hFFFF);
         lat = 3;
      end else begin
         w = ref_mem[addr[9:2]];
         for (int i = 0; i < size; i++) w[8*(off+i) +: 8] = wdata[8*i +: 8];
         ref_mem[addr[9:2]] = w;
         nwr = 1;
         lat = (size == 4) ? 2 : 4;
      end
   endtask

   task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic err, output logic [31:0] rd,
                          output int lat, output int nwr);
      bit ok;
      err = 1'b0; rd = '0; lat = 0; nwr = 0;
      @(negedge clk);
      req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      req_valid = 1'b1;
      ok = 0;
      for (int k = 0; k < 10; k++) begin
         if (req_ready) begin ok = 1; break; end
         @(negedge clk);
      end
      if (!ok) begin
         n_cmp++; n_bad++;
         $display("FAIL accept_timeout: got req_ready=0 expected 1");
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      ok = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (mem_wr_en) nwr++;
         if (rsp_valid) begin
            lat = k; rd = rsp_rdata; err = rsp_err; ok = 1;
            break;
         end
      end
      if (!ok) begin
         n_cmp++; n_bad++;
         $display("FAIL rsp_timeout: got no rsp_valid expected one within 10 cycles");
         return;
      end
      @(negedge clk);
      if (mem_wr_en) nwr++;
      chk("rsp_pulse", {31'd0, rsp_valid}, 32'd0);
   endtask

   task automatic exec(input string nm, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic e_err, input logic [31:0] e_rd, input int e_lat, input int e_wr);
      logic err;
      logic [31:0] rd;
      int lat, nwr;
      run_req(we, f3, addr, wdata, err, rd, lat, nwr);
      chk({nm, "_err"}, {31'd0, err}, {31'd0, e_err});
      chk({nm, "_rdata"}, rd, e_rd);
      chk({nm, "_lat"}, 32'(lat), 32'(e_lat));
      chk({nm, "_wr"}, 32'(nwr), 32'(e_wr));
   endtask

   initial begin
      logic        m_err;
      logic [31:0] m_rd;
      int          m_lat, m_wr, nw, nresp, idx;
      bit          will, prev;
      vec_t        q [3];
      logic [31:0] q_rd [3];
      logic        q_err [3];

      for (int i = 0; i < 256; i++) ref_mem[i] = '0;

      vec[0]  = '{1'b1, 3'd2, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0,        2, 1};
      vec[1]  = '{1'b0, 3'd2, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, 3, 0};
      vec[2]  = '{1'b1, 3'd2, 32'h20,  32'h11223344, 1'b0, 32'h0,        2, 1};
      vec[3]  = '{1'b1, 3'd0, 32'h22,  32'h000000AA, 1'b0, 32'h0,        4, 1};
      vec[4]  = '{1'b0, 3'd2, 32'h20,  32'h0,        1'b0, 32'h11AA3344, 3, 0};
      vec[5]  = '{1'b1, 3'd2, 32'h30,  32'h80FF7F01, 1'b0, 32'h0,        2, 1};
      vec[6]  = '{1'b0, 3'd0, 32'h31,  32'h0,        1'b0, 32'h0000007F, 3, 0};
      vec[7]  = '{1'b0, 3'd0, 32'h32,  32'h0,        1'b0, 32'hFFFFFFFF, 3, 0};
      vec[8]  = '{1'b0, 3'd4, 32'h32,  32'h0,        1'b0, 32'h000000FF, 3, 0};
      vec[9]  = '{1'b0, 3'd1, 32'h32,  32'h0,        1'b0, 32'hFFFF80FF, 3, 0};
      vec[10] = '{1'b0, 3'd5, 32'h32,  32'h0,        1'b0, 32'h000080FF, 3, 0};
      vec[11] = '{1'b0, 3'd0, 32'h33,  32'h0,        1'b0, 32'hFFFFFF80, 3, 0};
      vec[12] = '{1'b0, 3'd1, 32'h30,  32'h0,        1'b0, 32'h00007F01, 3, 0};
      vec[13] = '{1'b0, 3'd2, 32'h12,  32'h0,        1'b1, 32'h0,        1, 0};
      vec[14] = '{1'b1, 3'd1, 32'h13,  32'h12345678, 1'b1, 32'h0,        1, 0};
      vec[15] = '{1'b0, 3'd3, 32'h10,  32'h0,        1'b1, 32'h0,        1, 0};
      vec[16] = '{1'b0, 3'd2, 32'h400, 32'h0,        1'b1, 32'h0,        1, 0};
      vec[17] = '{1'b1, 3'd2, 32'h3FC, 32'h0BADF00D, 1'b0, 32'h0,        2, 1};
      vec[18] = '{1'b0, 3'd2, 32'h3FC, 32'h0,        1'b0, 32'h0BADF00D, 3, 0};
      vec[19] = '{1'b1, 3'd1, 32'h22,  32'hFFFF5566, 1'b0, 32'h0,        4, 1};
      vec[20] = '{1'b0, 3'd2, 32'h20,  32'h0,        1'b0, 32'h55663344, 3, 0};
      vec[21] = '{1'b1, 3'd4, 32'h10,  32'h000000AA, 1'b1, 32'h0,        1, 0};
      vec[22] = '{1'b0, 3'd2, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, 3, 0};

      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
      req_funct3 = '0; req_addr = '0; req_wdata = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_err", {31'd0, rsp_err}, 32'd0);
      chk("rst_maddr", mem_addr, 32'd0);
      chk("rst_mwdata", mem_wdata, 32'd0);
      chk("rst_wren", {31'd0, mem_wr_en}, 32'd0);

      for (int i = 0; i < 23; i++) begin
         model(vec[i].we, vec[i].f3, vec[i].addr, vec[i].wdata, m_err, m_rd, m_lat, m_wr);
         exec($sformatf("vec%0d", i), vec[i].we, vec[i].f3, vec[i].addr, vec[i].wdata,
              vec[i].e_err, vec[i].e_rd, vec[i].e_lat, vec[i].e_wr);
      end

      // reset while an SH is in LATCH: the RMW write must never land
      model(1'b1, 3'd2, 32'h40, 32'h55667788, m_err, m_rd, m_lat, m_wr);
      exec("pre_rst_sw", 1'b1, 3'd2, 32'h40, 32'h55667788, m_err, m_rd, m_lat, m_wr);
      @(negedge clk);
      req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h40; req_wdata = 32'h1234;
      req_valid = 1'b1;
      chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      nw = 0;
      @(negedge clk); if (mem_wr_en) nw++;
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk); if (mem_wr_en) nw++;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk); if (mem_wr_en) nw++;
      chk("mid_rst_ready_after", {31'd0, req_ready}, 32'd1);
      chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
      repeat (3) begin @(negedge clk); if (mem_wr_en) nw++; end
      chk("mid_rst_nowrite", 32'(nw), 32'd0);
      chk("mid_rst_mem", mem_arr[16], 32'h55667788);
      model(1'b0, 3'd2, 32'h40, 32'h0, m_err, m_rd, m_lat, m_wr);
      exec("post_rst_lw", 1'b0, 3'd2, 32'h40, 32'h0, m_err, m_rd, m_lat, m_wr);

      // back-to-back with req_valid held high across three requests
      q[0] = '{1'b1, 3'd2, 32'h50, 32'hCAFEF00D, 1'b0, 32'h0, 0, 0};
      q[1] = '{1'b1, 3'd0, 32'h51, 32'h00000099, 1'b0, 32'h0, 0, 0};
      q[2] = '{1'b0, 3'd2, 32'h50, 32'h0,        1'b0, 32'h0, 0, 0};
      for (int i = 0; i < 3; i++) begin
         model(q[i].we, q[i].f3, q[i].addr, q[i].wdata, q_err[i], q_rd[i], m_lat, m_wr);
      end
      @(negedge clk);
      req_we = q[0].we; req_funct3 = q[0].f3; req_addr = q[0].addr; req_wdata = q[0].wdata;
      req_valid = 1'b1;
      idx = 0; nresp = 0; prev = 0;
      for (int c = 0; c < 40 && nresp < 3; c++) begin
         if (c > 0) @(negedge clk);
         if (rsp_valid) begin
            chk($sformatf("b2b%0d_rdata", nresp), rsp_rdata, q_rd[nresp]);
            chk($sformatf("b2b%0d_err", nresp), {31'd0, rsp_err}, {31'd0, q_err[nresp]});
            chk($sformatf("b2b%0d_pulse", nresp), {31'd0, prev}, 32'd0);
            nresp++;
         end
         prev = rsp_valid;
         will = req_valid && req_ready;
         @(posedge clk);
         #1;
         if (will) begin
            idx++;
            if (idx < 3) begin
               req_we = q[idx].we; req_funct3 = q[idx].f3;
               req_addr = q[idx].addr; req_wdata = q[idx].wdata;
            end else begin
               req_valid = 1'b0;
            end
         end
      end
      req_valid = 1'b0;
      chk("b2b_accepts", 32'(idx), 32'd3);
      chk("b2b_resps", 32'(nresp), 32'd3);

      // random traffic against the reference model
      for (int i = 0; i < 150; i++) begin
         logic        r_we;
         logic [2:0]  r_f3;
         logic [31:0] r_addr, r_wd;
         int          sel;
         r_we = 1'($urandom_range(0, 1));
         r_f3 = 3'($urandom_range(0, 7));
         r_wd = $urandom;
         sel  = int'($urandom_range(0, 9));
         if (sel == 0)      r_addr = 32'h3F8 + $urandom_range(0, 15);
         else if (sel == 1) r_addr = $urandom;
         else               r_addr = $urandom_range(0, 255);
         model(r_we, r_f3, r_addr, r_wd, m_err, m_rd, m_lat, m_wr);
         exec($sformatf("rnd%0d", i), r_we, r_f3, r_addr, r_wd, m_err, m_rd, m_lat, m_wr);
      end

      for (int i = 0; i < 256; i++) begin
         chk($sformatf("mem[%0d]", i), mem_arr[i], ref_mem[i]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
